// File: rtl/ddr3_arb_pkg.sv
// Shared types and constants for the DDR3 app-interface arbiter.
// Imported by the arbiter top and its round-robin grant sub-module.
package ddr3_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WDATA = 3'd1,
      ST_CMD   = 3'd2,
      ST_RWAIT = 3'd3,
      ST_ACK   = 3'd4
   } state_t;

   localparam logic [2:0] APP_CMD_WR = 3'b000;
   localparam logic [2:0] APP_CMD_RD = 3'b001;

   typedef logic owner_t;

   localparam owner_t OWNER_IC = 1'b0;
   localparam owner_t OWNER_DC = 1'b1;

endpackage

// File: rtl/ddr3_rr_arb2.sv
// Two-way round-robin grant between I-cache and D-cache requests.
// Grants are combinational; last_grant advances only on a real grant.
module ddr3_rr_arb2
   import ddr3_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic req_ic,
   input  logic req_dc,
   output logic gnt_ic,
   output logic gnt_dc
);

   owner_t last_q;

   always_comb begin
      gnt_ic = 1'b0;
      gnt_dc = 1'b0;
      if (en) begin
         if (req_ic && req_dc) begin
            gnt_ic = (last_q == OWNER_DC);
            gnt_dc = (last_q == OWNER_IC);
         end else begin
            gnt_ic = req_ic;
            gnt_dc = req_dc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= OWNER_DC;
      end else if (gnt_ic) begin
         last_q <= OWNER_IC;
      end else if (gnt_dc) begin
         last_q <= OWNER_DC;
      end
   end

endmodule

// File: rtl/ddr3_app_arbiter.sv
// Shares the DDR3 controller app interface between I-cache and D-cache.
// One transaction in flight; outputs decode from registered state only.
module ddr3_app_arbiter
   import ddr3_arb_pkg::*;
#(
   parameter int ADR_W  = 28,
   parameter int DATA_W = 128,
   parameter int MASK_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_req,
   input  logic [ADR_W-1:0]  ic_adr,
   output logic              ic_ack,
   output logic [DATA_W-1:0] ic_rdata,
   input  logic              dc_req,
   input  logic              dc_we,
   input  logic [ADR_W-1:0]  dc_adr,
   input  logic [DATA_W-1:0] dc_wdata,
   input  logic [MASK_W-1:0] dc_wmask,
   output logic              dc_ack,
   output logic [DATA_W-1:0] dc_rdata,
   input  logic              init_calib_complete,
   output logic [ADR_W-1:0]  app_addr,
   output logic [2:0]        app_cmd,
   output logic              app_en,
   input  logic              app_rdy,
   output logic [DATA_W-1:0] app_wdf_data,
   output logic [MASK_W-1:0] app_wdf_mask,
   output logic              app_wdf_wren,
   output logic              app_wdf_end,
   input  logic              app_wdf_rdy,
   input  logic [DATA_W-1:0] app_rd_data,
   input  logic              app_rd_data_valid
);

   state_t              state;
   state_t              state_nx;
   owner_t              owner_q;
   logic [ADR_W-1:0]    addr_q;
   logic [2:0]          cmd_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [MASK_W-1:0]   wmask_q;
   logic [DATA_W-1:0]   ic_rdata_q;
   logic [DATA_W-1:0]   dc_rdata_q;
   logic                gnt_en;
   logic                gnt_ic;
   logic                gnt_dc;
   logic                grant;
   logic                cap;
   logic [ADR_W-1:0]    sel_adr;

   assign gnt_en = (state == ST_IDLE) && init_calib_complete;
   assign grant  = gnt_ic || gnt_dc;
   assign sel_adr = gnt_dc ? dc_adr : ic_adr;

   ddr3_rr_arb2 u_rr (
      .clk    (clk),
      .rst    (rst),
      .en     (gnt_en),
      .req_ic (ic_req),
      .req_dc (dc_req),
      .gnt_ic (gnt_ic),
      .gnt_dc (gnt_dc)
   );

   always_comb begin
      state_nx     = state;
      app_en       = 1'b0;
      app_wdf_wren = 1'b0;
      ic_ack       = 1'b0;
      dc_ack       = 1'b0;
      cap          = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (gnt_dc && dc_we) begin
               state_nx = ST_WDATA;
            end else if (grant) begin
               state_nx = ST_CMD;
            end
         end
         ST_WDATA: begin
            app_wdf_wren = 1'b1;
            if (app_wdf_rdy) begin
               state_nx = ST_CMD;
            end
         end
         ST_CMD: begin
            app_en = 1'b1;
            if (app_rdy) begin
               state_nx = (cmd_q == APP_CMD_WR) ? ST_ACK : ST_RWAIT;
            end
         end
         ST_RWAIT: begin
            if (app_rd_data_valid) begin
               cap      = 1'b1;
               state_nx = ST_ACK;
            end
         end
         ST_ACK: begin
            ic_ack   = (owner_q == OWNER_IC);
            dc_ack   = (owner_q == OWNER_DC);
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Commands always target the start of the BL8 burst.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         owner_q    <= OWNER_IC;
         addr_q     <= '0;
         cmd_q      <= APP_CMD_WR;
         wdata_q    <= '0;
         wmask_q    <= '0;
         ic_rdata_q <= '0;
         dc_rdata_q <= '0;
      end else begin
         state <= state_nx;
         if (grant) begin
            owner_q <= gnt_dc ? OWNER_DC : OWNER_IC;
            addr_q  <= {sel_adr[ADR_W-1:3], 3'b000};
            cmd_q   <= (gnt_dc && dc_we) ? APP_CMD_WR : APP_CMD_RD;
            wdata_q <= gnt_dc ? dc_wdata : '0;
            wmask_q <= gnt_dc ? dc_wmask : '0;
         end
         if (cap && (owner_q == OWNER_IC)) begin
            ic_rdata_q <= app_rd_data;
         end
         if (cap && (owner_q == OWNER_DC)) begin
            dc_rdata_q <= app_rd_data;
         end
      end
   end

   assign app_addr     = addr_q;
   assign app_cmd      = cmd_q;
   assign app_wdf_data = wdata_q;
   assign app_wdf_mask = wmask_q;
   assign app_wdf_end  = app_wdf_wren;
   assign ic_rdata     = ic_rdata_q;
   assign dc_rdata     = dc_rdata_q;

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Directed plus randomized bench for ddr3_app_arbiter with a
// transaction-level memory/round-robin reference and a controller model.
module tb_ddr3_app_arbiter;
   import ddr3_arb_pkg::*;

   localparam int AW = 28;
   localparam int DW = 128;
   localparam int MW = 16;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] adr;
      logic [DW-1:0] data;
      logic [MW-1:0] mask;
   } dop_t;

   logic          clk;
   logic          rst;
   logic          ic_req;
   logic [AW-1:0] ic_adr;
   logic          ic_ack;
   logic [DW-1:0] ic_rdata;
   logic          dc_req;
   logic          dc_we;
   logic [AW-1:0] dc_adr;
   logic [DW-1:0] dc_wdata;
   logic [MW-1:0] dc_wmask;
   logic          dc_ack;
   logic [DW-1:0] dc_rdata;
   logic          init_calib_complete;
   logic [AW-1:0] app_addr;
   logic [2:0]    app_cmd;
   logic          app_en;
   logic          app_rdy;
   logic [DW-1:0] app_wdf_data;
   logic [MW-1:0] app_wdf_mask;
   logic          app_wdf_wren;
   logic          app_wdf_end;
   logic          app_wdf_rdy;
   logic [DW-1:0] app_rd_data;
   logic          app_rd_data_valid;

   ddr3_app_arbiter dut (
      .clk                 (clk),
      .rst                 (rst),
      .ic_req              (ic_req),
      .ic_adr              (ic_adr),
      .ic_ack              (ic_ack),
      .ic_rdata            (ic_rdata),
      .dc_req              (dc_req),
      .dc_we               (dc_we),
      .dc_adr              (dc_adr),
      .dc_wdata            (dc_wdata),
      .dc_wmask            (dc_wmask),
      .dc_ack              (dc_ack),
      .dc_rdata            (dc_rdata),
      .init_calib_complete (init_calib_complete),
      .app_addr            (app_addr),
      .app_cmd             (app_cmd),
      .app_en              (app_en),
      .app_rdy             (app_rdy),
      .app_wdf_data        (app_wdf_data),
      .app_wdf_mask        (app_wdf_mask),
      .app_wdf_wren        (app_wdf_wren),
      .app_wdf_end         (app_wdf_end),
      .app_wdf_rdy         (app_wdf_rdy),
      .app_rd_data         (app_rd_data),
      .app_rd_data_valid   (app_rd_data_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests;
   int fails;
   int ic_acks;
   int dc_acks;
   int rd_cnt;
   int rd_lat;
   bit lat_rand;
   bit rdy_rand;
   bit stray;
   logic [AW-1:0] rd_adr;
   logic [DW-1:0] wbuf;
   logic [MW-1:0] wbm;
   owner_t ref_last;

   logic [DW-1:0] ref_mem [logic [AW-1:0]];
   logic [DW-1:0] ctl_mem [logic [AW-1:0]];
   logic [AW-1:0] ic_q [$];
   dop_t          dc_q [$];

   function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
      return {a, 4'h0, ~a, 4'hC, a ^ 28'h5A5A5A5, 4'h3, 32'h1234_5678};
   endfunction

   function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
      return {a[AW-1:3], 3'b000};
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                           input logic [DW-1:0] d,
                                           input logic [MW-1:0] m);
      logic [DW-1:0] r;
      r = old;
      for (int b = 0; b < MW; b++) begin
         if (!m[b]) r[b*8 +: 8] = d[b*8 +: 8];
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   function automatic logic [DW-1:0] ctl_rd(input logic [AW-1:0] a);
      return ctl_mem.exists(a) ? ctl_mem[a] : dflt(a);
   endfunction

   task automatic chk(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: controller model reacts to what the DUT showed at the edge.
   task automatic tick();
      logic          r;
      logic          acc_en;
      logic          acc_wr;
      logic [2:0]    c;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      logic [MW-1:0] wm;
      if (rdy_rand) begin
         app_rdy     = ($urandom_range(0, 3) != 0);
         app_wdf_rdy = ($urandom_range(0, 2) != 0);
      end
      r      = rst;
      acc_en = app_en & app_rdy;
      acc_wr = app_wdf_wren & app_wdf_rdy;
      c      = app_cmd;
      a      = app_addr;
      wd     = app_wdf_data;
      wm     = app_wdf_mask;
      @(posedge clk);
      #1;
      app_rd_data_valid = 1'b0;
      if (r) begin
         rd_cnt = 0;
      end else begin
         if (acc_wr) begin
            wbuf = wd;
            wbm  = wm;
         end
         if (acc_en && c == APP_CMD_WR) ctl_mem[a] = merge(ctl_rd(a), wbuf, wbm);
         if (acc_en && c == APP_CMD_RD) begin
            rd_adr = a;
            rd_cnt = lat_rand ? int'($urandom_range(1, 12)) : rd_lat;
         end
      end
      if (stray) begin
         app_rd_data_valid = 1'b1;
         app_rd_data       = {4{32'hBAD0_BAD0}};
         stray             = 1'b0;
      end else if (rd_cnt > 0) begin
         rd_cnt--;
         if (rd_cnt == 0) begin
            app_rd_data_valid = 1'b1;
            app_rd_data       = ctl_rd(rd_adr);
         end
      end
      ic_acks += int'(ic_ack);
      dc_acks += int'(dc_ack);
   endtask

   task automatic run_txns(input int budget);
      int            n;
      bit            ic_hold;
      bit            dc_hold;
      owner_t        obs;
      owner_t        exp;
      logic [AW-1:0] a;
      dop_t          op;
      n = 0;
      ic_hold = 1'b0;
      dc_hold = 1'b0;
      while ((ic_q.size() > 0 || dc_q.size() > 0) && n < budget) begin
         if (!ic_req && !ic_hold && ic_q.size() > 0) begin
            ic_req = 1'b1;
            ic_adr = ic_q[0];
         end
         if (!dc_req && !dc_hold && dc_q.size() > 0) begin
            op       = dc_q[0];
            dc_req   = 1'b1;
            dc_we    = op.we;
            dc_adr   = op.adr;
            dc_wdata = op.data;
            dc_wmask = op.mask;
         end
         ic_hold = 1'b0;
         dc_hold = 1'b0;
         tick();
         n++;
         if (ic_ack || dc_ack) begin
            chk("ack_excl", 128'(ic_ack & dc_ack), 128'd0);
            obs = dc_ack ? OWNER_DC : OWNER_IC;
            if (ic_q.size() > 0 && dc_q.size() > 0)
               exp = (ref_last == OWNER_DC) ? OWNER_IC : OWNER_DC;
            else
               exp = (ic_q.size() > 0) ? OWNER_IC : OWNER_DC;
            chk("grant_order", 128'(obs), 128'(exp));
            ref_last = exp;
            if (ic_ack && ic_q.size() > 0) begin
               a = align(ic_q.pop_front());
               chk("ic_rdata", ic_rdata, ref_rd(a));
               ic_req  = 1'b0;
               ic_hold = 1'b1;
            end
            if (dc_ack && dc_q.size() > 0) begin
               op = dc_q.pop_front();
               a  = align(op.adr);
               if (op.we) ref_mem[a] = merge(ref_rd(a), op.data, op.mask);
               else chk("dc_rdata", dc_rdata, ref_rd(a));
               dc_req  = 1'b0;
               dc_hold = 1'b1;
            end
         end
      end
      chk("run_done", 128'(ic_q.size() + dc_q.size()), 128'd0);
      ic_q.delete();
      dc_q.delete();
      ic_req = 1'b0;
      dc_req = 1'b0;
      tick();
   endtask

   initial begin
      int            n;
      int            bad;
      int            base;
      logic [DW-1:0] dd;
      logic [DW-1:0] w;
      dop_t          op;
      tests = 0;
      fails = 0;
      ic_acks = 0;
      dc_acks = 0;
      rd_cnt = 0;
      rd_lat = 4;
      lat_rand = 1'b0;
      rdy_rand = 1'b0;
      stray = 1'b0;
      rd_adr = '0;
      wbuf = '0;
      wbm = '0;
      ref_last = OWNER_DC;
      rst = 1'b1;
      ic_req = 1'b0;
      ic_adr = '0;
      dc_req = 1'b0;
      dc_we = 1'b0;
      dc_adr = '0;
      dc_wdata = '0;
      dc_wmask = '0;
      init_calib_complete = 1'b0;
      app_rdy = 1'b1;
      app_wdf_rdy = 1'b1;
      app_rd_data = '0;
      app_rd_data_valid = 1'b0;
      repeat (3) tick();

      chk("rst_app_en", 128'(app_en), 128'd0);
      chk("rst_wren", 128'(app_wdf_wren), 128'd0);
      chk("rst_wend", 128'(app_wdf_end), 128'd0);
      chk("rst_ic_ack", 128'(ic_ack), 128'd0);
      chk("rst_dc_ack", 128'(dc_ack), 128'd0);
      chk("rst_addr", 128'(app_addr), 128'd0);
      chk("rst_cmd", 128'(app_cmd), 128'd0);
      chk("rst_ic_rdata", ic_rdata, 128'd0);
      chk("rst_dc_rdata", dc_rdata, 128'd0);
      rst = 1'b0;

      dd = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
      ref_mem[28'h0000400] = dd;
      ctl_mem[28'h0000400] = dd;
      rd_lat = 10;
      ic_req = 1'b1;
      ic_adr = 28'h0000405;
      bad = 0;
      repeat (50) begin
         tick();
         if (app_en || app_wdf_wren) bad++;
      end
      chk("calib_gate", 128'(bad), 128'd0);
      init_calib_complete = 1'b1;
      n = 0;
      while (!app_en && n < 2) begin
         tick();
         n++;
      end
      chk("calib_en", 128'(app_en), 128'd1);
      chk("ic_addr", 128'(app_addr), 128'h0000400);
      chk("ic_cmd", 128'(app_cmd), 128'(APP_CMD_RD));
      base = ic_acks;
      n = 0;
      while (!ic_ack && n < 40) begin
         tick();
         n++;
      end
      chk("ic_ack", 128'(ic_ack), 128'd1);
      chk("ic_rd_latency", 128'(n), 128'd11);
      chk("ic_rdata_dead", ic_rdata, dd);
      ic_req = 1'b0;
      ref_last = OWNER_IC;
      repeat (3) tick();
      chk("ic_ack_once", 128'(ic_acks - base), 128'd1);
      chk("ic_rdata_hold", ic_rdata, dd);

      w = {$urandom, $urandom, $urandom, $urandom};
      app_wdf_rdy = 1'b0;
      dc_req = 1'b1;
      dc_we = 1'b1;
      dc_adr = 28'h0001000;
      dc_wdata = w;
      dc_wmask = 16'h00FF;
      base = dc_acks;
      n = 0;
      while (!app_wdf_wren && n < 5) begin
         tick();
         n++;
      end
      chk("wr_wren_start", 128'(app_wdf_wren), 128'd1);
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (!app_wdf_wren || app_en || !app_wdf_end) bad++;
         if (app_wdf_mask !== 16'h00FF || app_wdf_data !== w) bad++;
         if (i == 3) app_wdf_rdy = 1'b1;
         tick();
      end
      chk("wr_wren_hold", 128'(bad), 128'd0);
      chk("wr_wren_off", 128'(app_wdf_wren), 128'd0);
      chk("wr_en", 128'(app_en), 128'd1);
      chk("wr_cmd", 128'(app_cmd), 128'(APP_CMD_WR));
      chk("wr_addr", 128'(app_addr), 128'h0001000);
      n = 0;
      while (!dc_ack && n < 5) begin
         tick();
         n++;
      end
      chk("wr_ack", 128'(dc_ack), 128'd1);
      ref_mem[28'h0001000] = merge(ref_rd(28'h0001000), w, 16'h00FF);
      dc_req = 1'b0;
      ref_last = OWNER_DC;
      repeat (3) tick();
      chk("wr_ack_once", 128'(dc_acks - base), 128'd1);
      op = '{we: 1'b0, adr: 28'h0001004, data: '0, mask: '0};
      dc_q.push_back(op);
      run_txns(100);

      rd_lat = 3;
      ic_q.push_back(28'h0002001);
      ic_q.push_back(28'h0002011);
      op = '{we: 1'b1, adr: 28'h0002009, data: {4{32'h600D_F00D}}, mask: 16'hF0F0};
      dc_q.push_back(op);
      op = '{we: 1'b0, adr: 28'h0002008, data: '0, mask: '0};
      dc_q.push_back(op);
      run_txns(200);

      app_rdy = 1'b0;
      dc_req = 1'b1;
      dc_we = 1'b0;
      dc_adr = 28'h0003007;
      n = 0;
      while (!app_en && n < 5) begin
         tick();
         n++;
      end
      bad = 0;
      repeat (20) begin
         if (!app_en || app_addr !== 28'h0003000 || dc_ack || ic_ack) bad++;
         tick();
      end
      chk("bp_stable", 128'(bad), 128'd0);
      app_rdy = 1'b1;
      n = 0;
      while (!dc_ack && n < 30) begin
         tick();
         n++;
      end
      chk("bp_ack", 128'(dc_ack), 128'd1);
      chk("bp_rdata", dc_rdata, ref_rd(28'h0003000));
      dc_req = 1'b0;
      ref_last = OWNER_DC;
      repeat (2) tick();

      rd_lat = 10;
      ic_req = 1'b1;
      ic_adr = 28'h0004003;
      n = 0;
      while (!app_en && n < 5) begin
         tick();
         n++;
      end
      repeat (3) tick();
      rst = 1'b1;
      ic_req = 1'b0;
      tick();
      rst = 1'b0;
      ref_last = OWNER_DC;
      chk("mrst_app_en", 128'(app_en), 128'd0);
      chk("mrst_addr", 128'(app_addr), 128'd0);
      chk("mrst_cmd", 128'(app_cmd), 128'd0);
      chk("mrst_wdata", app_wdf_data, 128'd0);
      chk("mrst_wmask", 128'(app_wdf_mask), 128'd0);
      chk("mrst_dc_rdata", dc_rdata, 128'd0);
      stray = 1'b1;
      base = ic_acks + dc_acks;
      repeat (15) tick();
      chk("mrst_no_ack", 128'(ic_acks + dc_acks - base), 128'd0);
      chk("mrst_ic_rdata", ic_rdata, 128'd0);
      chk("mrst_idle_en", 128'(app_en), 128'd0);
      ic_q.push_back(28'h0004003);
      run_txns(100);

      rdy_rand = 1'b1;
      lat_rand = 1'b1;
      for (int i = 0; i < 10; i++) begin
         ic_q.push_back(28'h0005000 + 28'($urandom_range(0, 63)));
      end
      for (int i = 0; i < 12; i++) begin
         op.we   = 1'($urandom_range(0, 1));
         op.adr  = 28'h0005000 + 28'($urandom_range(0, 63));
         op.data = {$urandom, $urandom, $urandom, $urandom};
         op.mask = 16'($urandom);
         dc_q.push_back(op);
      end
      run_txns(3000);
      rdy_rand = 1'b0;
      lat_rand = 1'b0;
      app_rdy = 1'b1;
      app_wdf_rdy = 1'b1;
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
